// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU32 between two requesters.
// Round-robin grant, registered operands/function toward the ALU, result
// captured one cycle later and returned on a tagged valid/ready channel.
// Only one operation is in flight at a time (IDLE -> EXEC -> RESP).
// Optional feature macro: ALU_ARB_STATS_EN adds per-requester saturating
// grant counters (gnt_cnt0/gnt_cnt1) with a synchronous clear (stats_clr).
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [FUNC_W-1:0] req1_func,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [FUNC_W-1:0] alu_func,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

  // The ALU attached here is 32 bits wide and counters need at least one bit.
  if (DATA_W != 32 || CNT_W < 1) begin : g_bad_param
    $error("alu_share_arbiter: unsupported DATA_W/CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Requester granted most recently; starts at 1 so requester 0 wins the
  // first contended cycle after reset.
  logic last_gnt;
  logic win_any;
  logic win_id;
  logic accept;

  // Pick the winner: the sole valid requester, or the one not granted last.
  always_comb begin
    win_any = |req_valid;
    if (req_valid == 2'b11) begin
      win_id = ~last_gnt;
    end else begin
      win_id = req_valid[1];
    end
  end

  assign accept = (state == IDLE) && win_any;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a single operation walks IDLE -> EXEC -> RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: grant only while idle, and never while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state == IDLE) && win_any) begin
      req_ready[win_id] = 1'b1;
    end
  end

  // Operand/function capture on accept; registers hold between operations
  // so the ALU inputs do not toggle while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_func <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rsp_id   <= 1'b0;
      last_gnt <= 1'b1;
    end else if (accept) begin
      alu_func <= win_id ? req1_func : req0_func;
      alu_a    <= win_id ? req1_a    : req0_a;
      alu_b    <= win_id ? req1_b    : req0_b;
      rsp_id   <= win_id;
      last_gnt <= win_id;
    end
  end

  // Result capture one cycle after accept; response held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_y;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating grant counter for requester 0; clear beats a same-cycle grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
    end else if (stats_clr) begin
      gnt_cnt0 <= '0;
    end else if (accept && !win_id && !(&gnt_cnt0)) begin
      gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
    end
  end

  // Saturating grant counter for requester 1; clear beats a same-cycle grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt1 <= '0;
    end else if (stats_clr) begin
      gnt_cnt1 <= '0;
    end else if (accept && win_id && !(&gnt_cnt1)) begin
      gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: stand-in ALU, transaction-level model,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int FW = 4;
`ifdef ALU_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [FW-1:0] req0_func = '0, req1_func = '0;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [FW-1:0] alu_func;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic          rsp_valid, rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;
`endif

  always #5 clk = ~clk;

  // Stand-in ALU: any fixed function of (func, a, b) serves here.
  function automatic logic [31:0] alu_ref(logic [3:0] f, logic [31:0] a, logic [31:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      default: return (a * 32'd3) ^ b ^ {28'd0, f};
    endcase
  endfunction

  assign alu_y = alu_ref(alu_func, alu_a, alu_b);

  alu_share_arbiter #(.DATA_W(DW), .FUNC_W(FW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
    .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
`ifdef ALU_ARB_STATS_EN
    , .stats_clr(stats_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: one op outstanding at most; age = edges since its accept edge.
  bit          m_busy;
  int          m_age;
  bit          m_last;
  logic [3:0]  m_func;
  logic [31:0] m_a, m_b;
  bit          m_id;
  int          m_cnt [2];
  int          n_acc = 0;
  int          n_rsp = 0;
  bit          accepted;
  bit          acc_id;
  int          gnt_log [$];
  logic [32:0] rsp_log [$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_last = 1'b1;
    m_func = '0; m_a = '0; m_b = '0; m_id = 1'b0;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  // Round robin: sole valid wins; on contention the one not granted last.
  function automatic logic [1:0] pick(logic [1:0] v, bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic set_req(int i, logic [3:0] f, logic [31:0] a, logic [31:0] b);
    if (i == 0) begin
      req0_func = f; req0_a = a; req0_b = b;
    end else begin
      req1_func = f; req1_a = a; req1_b = b;
    end
    req_valid[i] = 1'b1;
  endtask

  // One clock cycle: compare DUT against model, advance model, move to next negedge.
  task automatic step();
    logic [1:0] er;
    bit ev;
    #1;
    er = m_busy ? 2'b00 : pick(req_valid, m_last);
    ev = m_busy && (m_age >= 2);
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, ev);
    chk("alu_func", alu_func, m_func);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("rsp_id", rsp_id, m_id);
    if (ev) chk("rsp_data", rsp_data, alu_ref(m_func, m_a, m_b));
`ifdef ALU_ARB_STATS_EN
    chk("gnt_cnt0", gnt_cnt0, m_cnt[0]);
    chk("gnt_cnt1", gnt_cnt1, m_cnt[1]);
`endif
    accepted = 0;
    if (er != 2'b00) begin
      accepted = 1;
      acc_id   = er[1];
      m_busy = 1; m_age = 1; m_last = acc_id; m_id = acc_id;
      m_func = acc_id ? req1_func : req0_func;
      m_a    = acc_id ? req1_a    : req0_a;
      m_b    = acc_id ? req1_b    : req0_b;
      gnt_log.push_back(int'(acc_id));
      n_acc++;
    end else if (m_busy) begin
      if (ev && rsp_ready) begin
        m_busy = 0;
        n_rsp++;
        rsp_log.push_back({rsp_id, rsp_data});
      end else if (m_age < 2) begin
        m_age++;
      end
    end
`ifdef ALU_ARB_STATS_EN
    if (stats_clr) begin
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (accepted && m_cnt[acc_id] < (1 << CW) - 1) begin
      m_cnt[acc_id]++;
    end
`endif
    @(negedge clk);
    if (accepted) req_valid[acc_id] = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(string nm);
    for (int k = 0; k < 30 && (m_busy || req_valid != 2'b00); k++) step();
    chk(nm, {m_busy, req_valid}, 3'b000);
  endtask

  initial begin
    int base;
    model_reset();
    req_valid = 2'b01;
    repeat (2) @(negedge clk);
    #1;
    // Reset state, with a request present to show ready stays low in reset.
    chk("reset req_ready", req_ready, 2'b00);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_id", rsp_id, 1'b0);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset alu_func", alu_func, 4'd0);
    chk("reset alu_a", alu_a, 32'd0);
    chk("reset alu_b", alu_b, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1) single request ADD 5+7
    rsp_ready = 1'b1;
    set_req(0, 4'd0, 32'd5, 32'd7);
    step();
    chk("t1 grant", {accepted, acc_id}, 2'b10);
    step();
    #1;
    chk("t1 rsp_valid", rsp_valid, 1'b1);
    chk("t1 rsp_id", rsp_id, 1'b0);
    chk("t1 rsp_data", rsp_data, 32'd12);
    drain("t1 drain");

    // 2) contention right after reset: requester 0 first
    apply_reset();
    rsp_log.delete();
    set_req(0, 4'd1, 32'd10, 32'd3);
    set_req(1, 4'd4, 32'hF0, 32'hFF);
    drain("t2 drain");
    chk("t2 count", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      chk("t2 first", rsp_log[0], {1'b0, 32'd7});
      chk("t2 second", rsp_log[1], {1'b1, 32'h0F});
    end

    // 3) both valid continuously for 12 cycles: four alternating grants
    base = gnt_log.size();
    for (int c = 0; c < 12; c++) begin
      if (!req_valid[0]) set_req(0, 4'($urandom_range(0, 15)), $urandom, $urandom);
      if (!req_valid[1]) set_req(1, 4'($urandom_range(0, 15)), $urandom, $urandom);
      step();
    end
    chk("t3 grants", gnt_log.size() - base, 4);
    if (gnt_log.size() - base == 4) begin
      chk("t3 order", {gnt_log[base][0], gnt_log[base+1][0], gnt_log[base+2][0], gnt_log[base+3][0]}, 4'b0101);
    end
    req_valid = 2'b00;
    drain("t3 drain");

    // 4) backpressure in RESP for 5 cycles, competing request waits
    rsp_ready = 1'b0;
    set_req(0, 4'd0, 32'd100, 32'd23);
    step();
    step();
    set_req(1, 4'd2, 32'hFF00, 32'h0FF0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4 hold ready", req_ready, 2'b00);
      chk("t4 hold data", rsp_data, 32'd123);
      step();
    end
    rsp_ready = 1'b1;
    step();
    step();
    chk("t4 next grant", {accepted, acc_id}, 2'b11);
    drain("t4 drain");

    // 5) reset while an op is in EXEC
    set_req(1, 4'd3, 32'h1234, 32'h8000);
    step();
    rst_n = 1'b0;
    #1;
    chk("t5 req_ready", req_ready, 2'b00);
    chk("t5 rsp_valid", rsp_valid, 1'b0);
    chk("t5 rsp_id", rsp_id, 1'b0);
    chk("t5 rsp_data", rsp_data, 32'd0);
    chk("t5 alu_a", alu_a, 32'd0);
    chk("t5 alu_b", alu_b, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    base = n_rsp;
    for (int c = 0; c < 6; c++) step();
    chk("t5 no response", n_rsp - base, 0);

`ifdef ALU_ARB_STATS_EN
    // 6) counters: three r1 grants reach all-ones, a fourth saturates,
    //    then clear wins over a same-cycle accept
    for (int g = 0; g < 3; g++) begin
      set_req(1, 4'd0, g, 32'd1);
      drain("t6 op");
    end
    chk("t6 cnt1 three", gnt_cnt1, 2'd3);
    set_req(1, 4'd0, 32'd9, 32'd9);
    drain("t6 sat op");
    chk("t6 cnt1 sat", gnt_cnt1, 2'd3);
    set_req(0, 4'd0, 32'd1, 32'd1);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("t6 clr accept", accepted, 1'b1);
    #1;
    chk("t6 cnt0 clr", gnt_cnt0, 2'd0);
    chk("t6 cnt1 clr", gnt_cnt1, 2'd0);
    drain("t6 drain");
`endif

    // Randomized traffic with backpressure and occasional withdrawal
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
`ifdef ALU_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 31) == 0);
`endif
      step();
    end
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    drain("final drain");
    chk("random progress", (n_rsp > 20), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
